lcd_xfer_arbiter: RTL and testbench
===================================

# lcd_xfer_arbiter

Round-robin arbiter and byte sequencer that shares the single `lcd_transfer` nibble engine between several LCD requesters, typically the init sequencer, a text writer and a cursor/line controller. Each requester submits either a full byte, sent as two nibbles, or a single nibble, plus a post-command delay. The block grants the engine, drives the nibble commands and returns a one-cycle acknowledge. An optional lock keeps multi-command sequences, such as the init sequence, from being interleaved.

## Interface
- `NREQ`, 2: number of requesters, 2..4.
- `NIBBLE_DELAY`, 21'd500: delay after a high nibble (10 µs at 50 MHz).
- `CLK` in 1: single clock.
- `RESET_N` in 1: reset is asynchronous and active-low.
- `req` in NREQ: request level per requester; held until its `ack`.
- `reqRs` in NREQ: RS value per requester; becomes command bit 4.
- `reqData` in NREQ×8: payload byte per requester.
- `reqNibble` in NREQ: 1 sends only `reqData[3:0]`.
- `reqDelay` in NREQ×21: delay after the final nibble, in clocks.
- `reqLock` in NREQ: hold the grant across consecutive transactions.
- `ack` out NREQ: one-cycle pulse when the transaction completes.
- `xferSend` out 1: command valid to `lcd_transfer`.
- `xferCmd` out 5: {RS, nibble}.
- `xferDelay` out 21: delay for the current nibble.
- `xferDone` in 1: one-cycle completion pulse from `lcd_transfer`.
- `busy` out 1: high in any state other than IDLE.
- `grantIdx` out 2: current or last granted requester.

## Operation
- States:
  - IDLE
  - SEND_HI
  - GAP
  - SEND_LO
  - ACK
- **IDLE**:
  - If any `req` is high, pick the winner g round-robin, starting at `lastGrant+1` modulo NREQ.
  - Latch `reqRs[g]`, `reqData[g]`, `reqNibble[g]` and `reqDelay[g]` into internal registers.
  - Next state is SEND_LO if `reqNibble[g]`, else SEND_HI.
- **SEND_HI**:
  - `xferSend=1`, `xferCmd={rs,data[7:4]}`, `xferDelay=NIBBLE_DELAY`.
  - On `xferDone`, go to GAP.
- **GAP**: one cycle with `xferSend=0`, then go to SEND_LO.
- **SEND_LO**:
  - `xferSend=1`, `xferCmd={rs,data[3:0]}`, `xferDelay=latched delay`.
  - On `xferDone`, go to ACK.
- **ACK**:
  - `ack[g]=1` for one cycle.
  - `lastGrant` is set to g.
  - Go to IDLE.
- Payload is latched at grant. Requester changes after grant are ignored.
- If `req[g]` drops mid-transaction, the transaction still completes and `ack[g]` still pulses.
- `xferDone` outside SEND_HI/SEND_LO is ignored.
- `xferDone` arriving in the same cycle `xferSend` rises counts as completion.
- All registered outputs go to 0 on reset: `xferSend`, `xferCmd`, `xferDelay`, `ack`, `busy`, `grantIdx`. `lastGrant` resets to NREQ-1, so requester 0 wins first.
- `RESET_N` low mid-transfer aborts immediately. No `ack` is issued.

## Timing
- The grant decision is made in the IDLE cycle in which `req` is seen. `xferSend` rises the next cycle.
- `xferCmd` and `xferDelay` are registered and stable for the whole time `xferSend` is high.
- `xferSend` falls in the cycle after `xferDone` is sampled.
- Byte transaction: `ack` comes 3 cycles after the second `xferDone` edge relative to the first; there is a fixed 1-cycle GAP between nibbles.
- Back-to-back requests: a new grant can occur in the IDLE cycle directly after ACK, so there are 2 dead cycles between transactions.

## Configuration
- `LCD_ARB_LOCK_EN` defined: the lock is active.
  - If `reqLock[lastGrant]` is high in IDLE, only `req[lastGrant]` is eligible. Other requesters wait even if `req[lastGrant]` is low.
  - The lock is released when `reqLock[lastGrant]` drops.
- `LCD_ARB_LOCK_EN` undefined: the `reqLock` port remains but is ignored, and arbitration is pure round-robin.

## Structure
- `lcd_pkg` holds:
  - `lcd_arb_state_t` enum: IDLE, SEND_HI, GAP, SEND_LO, ACK.
  - `LCD_DELAY_W=21`.
  - `LCD_CMD_W=5`.
  - `LCD_RS_BIT=4`.
  - Shared timing constants: `T1US`, `T10US`, `T53US`.
- Sub-module `lcd_rr_arbiter`: combinational round-robin winner selection from `req`, `lastGrant` and lock mask. Outputs `valid` and `idx`.

## Test plan
- **Single byte, no contention:** req[1]=1, reqRs=1, reqData=8'h41, reqDelay=2500, with `xferDone` returned 5 cycles after each send.
  - Expect xferCmd=5'h14 with delay 500, then 5'h11 with delay 2500.
  - Expect ack[1] exactly once and xferSend low for 1 cycle between the nibbles.
- **Nibble-only:** req[0]=1, reqNibble=1, reqData=8'h03, reqDelay=205000.
  - Expect one command, xferCmd=5'h03 with delay 205000, then ack[0].
- **Contention:** req[0] and req[1] both held high for 4 transactions.
  - Expect grant order 0, 1, 0, 1.
  - Expect no ack overlap and grantIdx to match each ack.
- **Lock** (with `LCD_ARB_LOCK_EN`): req0 has reqLock=1 for 3 transactions while req[1] is held high.
  - Expect 3 consecutive acks to 0, then ack[1] after reqLock[0] drops.
  - Without the macro, expect alternating 0, 1.
- **Reset mid-transfer:** drop RESET_N during SEND_LO.
  - Expect xferSend=0 and busy=0 immediately, no ack, and requester 0 winning first after release.
- **Robustness:** drop req mid-byte and inject a stray `xferDone` in IDLE.
  - Expect the byte to complete with ack, and the stray `xferDone` to change no state.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared LCD widths, timing constants and arbiter state type
package lcd_pkg;

    localparam int LCD_DELAY_W = 21;
    localparam int LCD_CMD_W   = 5;
    localparam int LCD_RS_BIT  = 4;

    // Delay counts at a 50 MHz clock
    localparam logic [LCD_DELAY_W-1:0] T1US  = 21'd50;
    localparam logic [LCD_DELAY_W-1:0] T10US = 21'd500;
    localparam logic [LCD_DELAY_W-1:0] T53US = 21'd2650;

    typedef enum logic [2:0] {
        IDLE,
        SEND_HI,
        GAP,
        SEND_LO,
        ACK
    } lcd_arb_state_t;

    function automatic logic [LCD_CMD_W-1:0] mkCmd(input logic rs, input logic [3:0] nib);
        logic [LCD_CMD_W-1:0] c;
        c             = '0;
        c[3:0]        = nib;
        c[LCD_RS_BIT] = rs;
        return c;
    endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// rtl/lcd_rr_arbiter.sv - combinational round-robin winner pick starting after lastGrant
module lcd_rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      lastGrant,
    input  logic [NREQ-1:0] lockMask,
    output logic            valid,
    output logic [1:0]      idx
);

    logic [NREQ-1:0] eligible;

    assign eligible = req & lockMask;

    // Walk offsets from farthest to nearest so the requester right after lastGrant wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            for (int j = 0; j < NREQ; j++) begin
                if (j == (int'(lastGrant) + k) % NREQ && eligible[j]) begin
                    valid = 1'b1;
                    idx   = 2'(j);
                end
            end
        end
    end

endmodule

// File: rtl/lcd_xfer_arbiter.sv
// rtl/lcd_xfer_arbiter.sv - shares one lcd_transfer nibble engine among NREQ requesters
// LCD_ARB_LOCK_EN: when defined, reqLock keeps the grant on the last winner.
module lcd_xfer_arbiter
    import lcd_pkg::*;
#(
    parameter int                      NREQ         = 2,
    parameter logic [LCD_DELAY_W-1:0]  NIBBLE_DELAY = 21'd500
) (
    input  logic                                CLK,
    input  logic                                RESET_N,
    input  logic [NREQ-1:0]                     req,
    input  logic [NREQ-1:0]                     reqRs,
    input  logic [NREQ-1:0][7:0]                reqData,
    input  logic [NREQ-1:0]                     reqNibble,
    input  logic [NREQ-1:0][LCD_DELAY_W-1:0]    reqDelay,
    input  logic [NREQ-1:0]                     reqLock,
    output logic [NREQ-1:0]                     ack,
    output logic                                xferSend,
    output logic [LCD_CMD_W-1:0]                xferCmd,
    output logic [LCD_DELAY_W-1:0]              xferDelay,
    input  logic                                xferDone,
    output logic                                busy,
    output logic [1:0]                          grantIdx
);

    lcd_arb_state_t          state;
    logic [1:0]              lastGrant;
    logic                    latRs;
    logic [3:0]              latLo;
    logic [LCD_DELAY_W-1:0]  latDelay;

    logic [NREQ-1:0]         lockMask;
    logic                    winValid;
    logic [1:0]              winIdx;
    logic                    selRs;
    logic                    selNibble;
    logic [7:0]              selData;
    logic [LCD_DELAY_W-1:0]  selDelay;
    logic [NREQ-1:0]         grantOneHot;

`ifdef LCD_ARB_LOCK_EN
    // A locked last winner is the only eligible requester, even while its req is low.
    always_comb begin
        lockMask = '1;
        for (int j = 0; j < NREQ; j++) begin
            if (j == int'(lastGrant) && reqLock[j]) begin
                lockMask    = '0;
                lockMask[j] = 1'b1;
            end
        end
    end
`else
    logic unusedLock;
    assign lockMask   = '1;
    assign unusedLock = ^reqLock;
`endif

    lcd_rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req       (req),
        .lastGrant (lastGrant),
        .lockMask  (lockMask),
        .valid     (winValid),
        .idx       (winIdx)
    );

    always_comb begin
        selRs     = 1'b0;
        selNibble = 1'b0;
        selData   = '0;
        selDelay  = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (j == int'(winIdx)) begin
                selRs     = reqRs[j];
                selNibble = reqNibble[j];
                selData   = reqData[j];
                selDelay  = reqDelay[j];
            end
        end
    end

    always_comb begin
        grantOneHot = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (j == int'(grantIdx)) begin
                grantOneHot[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            xferSend  <= 1'b0;
            xferCmd   <= '0;
            xferDelay <= '0;
            ack       <= '0;
            busy      <= 1'b0;
            grantIdx  <= '0;
            lastGrant <= 2'(NREQ - 1);
            latRs     <= 1'b0;
            latLo     <= '0;
            latDelay  <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (winValid) begin
                        grantIdx <= winIdx;
                        latRs    <= selRs;
                        latLo    <= selData[3:0];
                        latDelay <= selDelay;
                        busy     <= 1'b1;
                        xferSend <= 1'b1;
                        if (selNibble) begin
                            state     <= SEND_LO;
                            xferCmd   <= mkCmd(selRs, selData[3:0]);
                            xferDelay <= selDelay;
                        end else begin
                            state     <= SEND_HI;
                            xferCmd   <= mkCmd(selRs, selData[7:4]);
                            xferDelay <= NIBBLE_DELAY;
                        end
                    end
                end
                SEND_HI: begin
                    if (xferDone) begin
                        xferSend <= 1'b0;
                        state    <= GAP;
                    end
                end
                GAP: begin
                    xferSend  <= 1'b1;
                    xferCmd   <= mkCmd(latRs, latLo);
                    xferDelay <= latDelay;
                    state     <= SEND_LO;
                end
                SEND_LO: begin
                    if (xferDone) begin
                        xferSend <= 1'b0;
                        ack      <= grantOneHot;
                        state    <= ACK;
                    end
                end
                ACK: begin
                    lastGrant <= grantIdx;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    xferSend <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_xfer_arbiter.sv
// tb/tb_lcd_xfer_arbiter.sv - scoreboard bench with a transaction-level arbitration model
module tb_lcd_xfer_arbiter;

    localparam int          NREQ  = 3;
    localparam logic [20:0] NIB_D = 21'd500;

    logic                     CLK = 1'b0;
    logic                     RESET_N;
    logic [NREQ-1:0]          req;
    logic [NREQ-1:0]          reqRs;
    logic [NREQ-1:0][7:0]     reqData;
    logic [NREQ-1:0]          reqNibble;
    logic [NREQ-1:0][20:0]    reqDelay;
    logic [NREQ-1:0]          reqLock;
    logic [NREQ-1:0]          ack;
    logic                     xferSend;
    logic [4:0]               xferCmd;
    logic [20:0]              xferDelay;
    logic                     xferDone;
    logic                     engDone;
    logic                     strayDone;
    logic                     busy;
    logic [1:0]               grantIdx;

    always #5 CLK = ~CLK;
    assign xferDone = engDone | strayDone;

    lcd_xfer_arbiter #(.NREQ(NREQ), .NIBBLE_DELAY(NIB_D)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .req       (req),
        .reqRs     (reqRs),
        .reqData   (reqData),
        .reqNibble (reqNibble),
        .reqDelay  (reqDelay),
        .reqLock   (reqLock),
        .ack       (ack),
        .xferSend  (xferSend),
        .xferCmd   (xferCmd),
        .xferDelay (xferDelay),
        .xferDone  (xferDone),
        .busy      (busy),
        .grantIdx  (grantIdx)
    );

    typedef struct {
        logic        rs;
        logic [7:0]  data;
        logic        nib;
        logic [20:0] delay;
        logic        lock;
    } item_t;

    typedef struct {
        logic [4:0]  cmd;
        logic [20:0] delay;
        logic        isHi;
    } exp_t;

    item_t pend[NREQ][$];
    bit    dropMask[NREQ];
    exp_t  expCmd[$];
    int    expAck[$];
    int    checks    = 0;
    int    errors    = 0;
    int    modelLast = NREQ - 1;
    int    sendRises = 0;
    int    respLat   = -1;
    bit    respEn    = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic item_t mkItem(input logic rs, input logic [7:0] data, input logic nib,
                                     input logic [20:0] delay, input logic lock);
        item_t it;
        it.rs = rs; it.data = data; it.nib = nib; it.delay = delay; it.lock = lock;
        return it;
    endfunction

    function automatic bit anyPend();
        for (int r = 0; r < NREQ; r++) if (pend[r].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: every requester with queued work keeps req high; winner is the first
    // requester with work after the previous winner, unless that winner holds the lock.
    function automatic void predict();
        item_t q[NREQ][$];
        item_t it;
        exp_t  e;
        int    lg;
        int    w;
        for (int r = 0; r < NREQ; r++) q[r] = pend[r];
        lg = modelLast;
        while (1) begin
            w = -1;
`ifdef LCD_ARB_LOCK_EN
            if (q[lg].size() != 0 && q[lg][0].lock) w = lg;
`endif
            for (int k = 1; k <= NREQ; k++) begin
                int c = (lg + k) % NREQ;
                if (w < 0 && q[c].size() != 0) w = c;
            end
            if (w < 0) break;
            it = q[w].pop_front();
            if (!it.nib) begin
                e.cmd = {it.rs, it.data[7:4]}; e.delay = NIB_D; e.isHi = 1'b1;
                expCmd.push_back(e);
            end
            e.cmd = {it.rs, it.data[3:0]}; e.delay = it.delay; e.isHi = 1'b0;
            expCmd.push_back(e);
            expAck.push_back(w);
            lg = w;
        end
        modelLast = lg;
    endfunction

    // Requester side: front of each queue is presented until its ack.
    task automatic driveTick();
        item_t it;
        @(negedge CLK);
        for (int r = 0; r < NREQ; r++) begin
            if (ack[r] && pend[r].size() != 0) begin
                void'(pend[r].pop_front());
                dropMask[r] = 1'b0;
            end
        end
        for (int r = 0; r < NREQ; r++) begin
            if (pend[r].size() != 0 && !dropMask[r]) begin
                it           = pend[r][0];
                req[r]       = 1'b1;
                reqRs[r]     = it.rs;
                reqData[r]   = it.data;
                reqNibble[r] = it.nib;
                reqDelay[r]  = it.delay;
                reqLock[r]   = it.lock;
            end else begin
                req[r]     = 1'b0;
                reqLock[r] = 1'b0;
                if (dropMask[r]) begin
                    reqData[r] = 8'($urandom);
                    reqRs[r]   = ~reqRs[r];
                end
            end
        end
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((expAck.size() != 0 || busy || anyPend()) && n < budget) begin
            driveTick();
            n++;
        end
        chk("drain_in_budget", 32'(n < budget), 32'd1);
        repeat (2) driveTick();
    endtask

    task automatic runBatch();
        predict();
        waitDrain(3000);
    endtask

    task automatic randomBatch();
        int n;
        for (int r = 0; r < NREQ; r++) begin
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++)
                pend[r].push_back(mkItem(1'($urandom_range(0, 1)), 8'($urandom),
                                         $urandom_range(0, 3) == 0, 21'($urandom),
                                         $urandom_range(0, 3) == 0));
        end
        runBatch();
    endtask

    task automatic waitRises(input int target);
        int n = 0;
        while (sendRises < target && n < 200) begin
            driveTick();
            n++;
        end
        chk("send_rise_in_budget", 32'(sendRises >= target), 32'd1);
    endtask

    // lcd_transfer stand-in: one done pulse per command, latency 0..4 or fixed
    initial begin
        int d;
        engDone = 1'b0;
        forever begin
            @(negedge CLK);
            if (respEn && RESET_N && xferSend) begin
                d = (respLat < 0) ? $urandom_range(0, 4) : respLat;
                repeat (d) @(negedge CLK);
                engDone = 1'b1;
                @(negedge CLK);
                engDone = 1'b0;
            end
        end
    end

    // Monitor: pops expected commands and acks as the DUT presents them.
    initial begin
        bit   prevSend = 1'b0;
        bit   curValid = 1'b0;
        bit   prevHi   = 1'b0;
        int   lowRun   = 0;
        int   e;
        exp_t cur;
        forever begin
            @(negedge CLK);
            if (!RESET_N) begin
                prevSend = 1'b0; curValid = 1'b0; prevHi = 1'b0; lowRun = 0;
            end else begin
                if (xferSend && !prevSend) begin
                    sendRises++;
                    if (expCmd.size() == 0) begin
                        checks++; errors++; curValid = 1'b0;
                        $display("FAIL cmd_unexpected: got cmd 0x%0h with none expected at %0t", xferCmd, $time);
                    end else begin
                        cur = expCmd.pop_front();
                        curValid = 1'b1;
                        if (!cur.isHi && prevHi) chk("nibble_gap", 32'(lowRun), 32'd1);
                        prevHi = cur.isHi;
                    end
                    lowRun = 0;
                end
                if (xferSend && curValid) begin
                    chk("xfer_cmd", 32'(xferCmd), 32'(cur.cmd));
                    chk("xfer_delay", 32'(xferDelay), 32'(cur.delay));
                    chk("busy_in_send", 32'(busy), 32'd1);
                end
                if (!xferSend && prevSend && curValid && !cur.isHi)
                    chk("ack_after_lo", 32'(ack != '0), 32'd1);
                if (!xferSend) lowRun++;
                if (ack != '0) begin
                    if (expAck.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ack_unexpected: got ack 0x%0h with none expected at %0t", ack, $time);
                    end else begin
                        e = expAck.pop_front();
                        chk("ack_vec", 32'(ack), 32'(1) << e);
                        chk("ack_grant_idx", 32'(grantIdx), 32'(e));
                    end
                end
                prevSend = xferSend;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: run exceeded time limit");
        $fatal(1, "stopped");
    end

    initial begin
        int s0;
        req = '0; reqRs = '0; reqData = '0; reqNibble = '0; reqDelay = '0; reqLock = '0;
        strayDone = 1'b0;
        for (int r = 0; r < NREQ; r++) dropMask[r] = 1'b0;
        RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_xferSend", 32'(xferSend), 32'd0);
        chk("rst_xferCmd", 32'(xferCmd), 32'd0);
        chk("rst_xferDelay", 32'(xferDelay), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grantIdx", 32'(grantIdx), 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Nibble-only command
        pend[0].push_back(mkItem(1'b0, 8'h03, 1'b1, 21'd205000, 1'b0));
        runBatch();

        // Single byte, engine answers 5 cycles after each send
        respLat = 5;
        pend[1].push_back(mkItem(1'b1, 8'h41, 1'b0, 21'd2500, 1'b0));
        runBatch();
        respLat = -1;

        // Contention between 0 and 1
        for (int i = 0; i < 2; i++) begin
            pend[0].push_back(mkItem(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 21'($urandom), 1'b0));
            pend[1].push_back(mkItem(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 21'($urandom), 1'b0));
        end
        runBatch();

        // Lock held by requester 0 for three transactions
        for (int i = 0; i < 3; i++)
            pend[0].push_back(mkItem(1'b0, 8'($urandom), 1'($urandom_range(0, 1)), 21'($urandom), 1'b1));
        for (int i = 0; i < 2; i++)
            pend[1].push_back(mkItem(1'b1, 8'($urandom), 1'b0, 21'($urandom), 1'b0));
        runBatch();

        for (int b = 0; b < 20; b++) randomBatch();

        // Reset during SEND_LO
        respLat = 3;
        pend[1].push_back(mkItem(1'b1, 8'hA5, 1'b0, 21'd100, 1'b0));
        predict();
        s0 = sendRises;
        waitRises(s0 + 1);
        respEn = 1'b0;
        waitRises(s0 + 2);
        repeat (2) driveTick();
        #2 RESET_N = 1'b0;
        #1;
        chk("abort_xferSend", 32'(xferSend), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ack", 32'(ack), 32'd0);
        for (int r = 0; r < NREQ; r++) pend[r].delete();
        expCmd.delete();
        expAck.delete();
        modelLast = NREQ - 1;
        repeat (3) driveTick();
        RESET_N = 1'b1;
        respEn  = 1'b1;
        respLat = -1;
        repeat (4) driveTick();
        pend[1].push_back(mkItem(1'b0, 8'h3C, 1'b0, 21'd40, 1'b0));
        pend[0].push_back(mkItem(1'b1, 8'hC3, 1'b0, 21'd60, 1'b0));
        runBatch();

        // req dropped and payload scrambled mid-byte, then a stray done while idle
        pend[2].push_back(mkItem(1'b1, 8'h5A, 1'b0, 21'd77, 1'b0));
        predict();
        s0 = sendRises;
        waitRises(s0 + 1);
        dropMask[2] = 1'b1;
        waitDrain(3000);
        strayDone = 1'b1;
        driveTick();
        strayDone = 1'b0;
        for (int i = 0; i < 3; i++) begin
            driveTick();
            #1;
            chk("stray_busy", 32'(busy), 32'd0);
            chk("stray_send", 32'(xferSend), 32'd0);
        end

        for (int b = 0; b < 5; b++) randomBatch();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
